cs_fci_func: RTL and testbench

- Combinational round function F_ci of the CS-Cipher key schedule: oword = T(P8(iword XOR ci)).
- P8 applies the 8-bit CS-Cipher permutation P to each byte. T is the 8x8 bit-matrix transposition.
- Instantiated inside the key-schedule sequencer, which computes k_i = k_{i-2} XOR F_ci(k_{i-1}) in the same clock cycle. The output therefore has zero latency.

---
 rtl/cs_fci_func.sv | 88 ++++++++
 tb/tb_cs_fci_func.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cs_fci_func.sv
// -----------------------------------------------------------------------------
// cs_fci_func
//   Round function F_ci of the CS-Cipher key schedule:
//     oword = T(P8(iword ^ ci))
//   P8 substitutes every byte through the 8-bit permutation P.
//   T is the 8x8 bit-matrix transpose.
//   The block is purely combinational, so the result is available in the
//   same cycle. The key-schedule sequencer relies on that to form
//   k_i = k_{i-2} ^ F_ci(k_{i-1}) within one clock.
//
// Ports
//   clk    in   1   clock, kept only for interface uniformity (unused)
//   rst    in   1   synchronous active-high reset, no effect on oword
//   ci     in  64   round constant c_i
//   iword  in  64   input word k_{i-1}
//   oword  out 64   F_ci(iword), zero latency, no reset value
// -----------------------------------------------------------------------------
module cs_fci_func (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ci,
  input  logic [63:0] iword,
  output logic [63:0] oword
);

  // clk/rst are part of the common sequencer-facing interface only.
  logic unused_inputs;
  assign unused_inputs = clk ^ rst;

  // Nibble function f of the P network.
  function automatic logic [3:0] f_nib(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hF;  4'h1: r = 4'hD;  4'h2: r = 4'hB;  4'h3: r = 4'hB;
      4'h4: r = 4'h7;  4'h5: r = 4'h5;  4'h6: r = 4'h7;  4'h7: r = 4'h7;
      4'h8: r = 4'hE;  4'h9: r = 4'hD;  4'hA: r = 4'hA;  4'hB: r = 4'hB;
      4'hC: r = 4'hE;  4'hD: r = 4'hD;  4'hE: r = 4'hE;  4'hF: r = 4'hF;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Nibble function g of the P network.
  function automatic logic [3:0] g_nib(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hA;  4'h1: r = 4'h6;  4'h2: r = 4'h0;  4'h3: r = 4'h2;
      4'h4: r = 4'hB;  4'h5: r = 4'hE;  4'h6: r = 4'h1;  4'h7: r = 4'h8;
      4'h8: r = 4'hD;  4'h9: r = 4'h4;  4'hA: r = 4'h5;  4'hB: r = 4'h3;
      4'hC: r = 4'hF;  4'hD: r = 4'hC;  4'hE: r = 4'h7;  4'hF: r = 4'h9;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Three-round Feistel-like network on the two nibbles of a byte.
  function automatic logic [7:0] p_byte(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] yr;
    logic [3:0] yl;
    t  = v[7:4] ^ f_nib(v[3:0]);
    yr = v[3:0] ^ g_nib(t);
    yl = t ^ f_nib(yr);
    return {yl, yr};
  endfunction

  logic [63:0] x_c;
  logic [63:0] y_c;
  logic [63:0] oword_c;

  always_comb begin
    x_c     = iword ^ ci;
    y_c     = '0;
    oword_c = '0;
    for (int j = 0; j < 8; j++) begin
      y_c[8*j +: 8] = p_byte(x_c[8*j +: 8]);
    end
    // Output byte i collects bit i of every substituted byte.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        oword_c[8*i + j] = y_c[8*j + i];
      end
    end
  end

  assign oword = oword_c;

endmodule

// File: tb/tb_cs_fci_func.sv
module tb_cs_fci_func;

  logic        clk;
  logic        rst;
  logic [63:0] ci;
  logic [63:0] iword;
  logic [63:0] oword;

  cs_fci_func dut (
    .clk   (clk),
    .rst   (rst),
    .ci    (ci),
    .iword (iword),
    .oword (oword)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    logic [63:0] ci_v;
    logic [63:0] iw_v;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    pass_cnt = 0;
  int    tot_cnt  = 0;

  localparam logic [3:0] F_TAB [16] = '{4'hF,4'hD,4'hB,4'hB,4'h7,4'h5,4'h7,4'h7,
                                        4'hE,4'hD,4'hA,4'hB,4'hE,4'hD,4'hE,4'hF};
  localparam logic [3:0] G_TAB [16] = '{4'hA,4'h6,4'h0,4'h2,4'hB,4'hE,4'h1,4'h8,
                                        4'hD,4'h4,4'h5,4'h3,4'hF,4'hC,4'h7,4'h9};
  localparam logic [7:0] P_REF [16] = '{8'h29,8'h0D,8'h61,8'h40,8'h9C,8'hEB,8'h9E,8'h8F,
                                        8'h1F,8'h85,8'h5F,8'h58,8'h5B,8'h01,8'h39,8'h86};

  // Reference P from the nibble formula.
  function automatic logic [7:0] p_model(input int v);
    int a, b, t, yr, yl;
    a  = (v >> 4) & 15;
    b  = v & 15;
    t  = a ^ int'(F_TAB[b]);
    yr = b ^ int'(G_TAB[t]);
    yl = t ^ int'(F_TAB[yr]);
    return 8'((yl << 4) | yr);
  endfunction

  // Expected word when every byte maps to the same value p.
  function automatic logic [63:0] splat(input logic [7:0] p);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = p[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Full software reference T(P8(iw ^ c)).
  function automatic logic [63:0] f_model(input logic [63:0] c, input logic [63:0] iw);
    logic [7:0]  y [8];
    logic [63:0] x, r;
    x = iw ^ c;
    for (int j = 0; j < 8; j++) y[j] = p_model(int'(x[8*j +: 8]));
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r[8*i + j] = y[j][i];
    return r;
  endfunction

  task automatic send(input logic [63:0] c, input logic [63:0] iw,
                      input logic r, input logic [63:0] e, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    ci    = c;
    iword = iw;
    rst   = r;
    it.exp  = e;
    it.ci_v = c;
    it.iw_v = iw;
    it.name = nm;
    sb_q.push_back(it);
  endtask

  // Monitor: compares the settled output mid-cycle against the queued expectation.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        tot_cnt++;
        if (oword === it.exp) pass_cnt++;
        else $display("FAIL %s ci=%h iword=%h got=%h exp=%h",
                      it.name, it.ci_v, it.iw_v, oword, it.exp);
      end
    end
  end

  initial begin
    logic [63:0] c, iw;
    logic [7:0]  pe;
    int          wait_cyc;
    rst   = 1'b1;
    ci    = '0;
    iword = '0;

    send(64'h0, 64'h0, 1'b1, 64'h0000FF00FF0000FF, "zero_rst1");
    send(64'h0, 64'h0, 1'b0, 64'h0000FF00FF0000FF, "zero_rst0");
    send(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 64'h0000FF00FF0000FF, "cancel");
    send(64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h00FF00FF00FF00FF, "all_ones");
    send(64'h0, 64'h1, 1'b0, 64'h0000FE00FF0100FF, "single_byte");
    send(64'h1, 64'h0, 1'b1, 64'h0000FE00FF0100FF, "single_swap");
    send(64'h0, 64'h0000000000000001, 1'b0, f_model(64'h0, 64'h1), "model_single");

    for (int v = 0; v < 256; v++) begin
      pe = (v < 16) ? P_REF[v] : p_model(v);
      send(64'h0, {8{8'(v)}}, 1'b0, splat(pe), "exhaustive_p");
    end

    for (int n = 0; n < 10000; n++) begin
      c  = {$urandom(), $urandom()};
      iw = {$urandom(), $urandom()};
      send(c, iw, 1'($urandom_range(0, 1)), f_model(c, iw), "random");
    end

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      tot_cnt++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
